fixed_point_complex_multiplier: RTL and testbench

//  Twiddle-factor multiply stage of the FFT butterfly. Computes P = A * W for complex Q1.15

---
 rtl/fixed_point_complex_multiplier.sv | 163 ++++++++++++++++
 tb/tb_fixed_point_complex_multiplier.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/fixed_point_complex_multiplier.sv
// Complex Q1.15 twiddle multiply P = A * W using one time-shared signed multiplier.
// Four multiply cycles accumulate into 33-bit sums; the OUT cycle floors, saturates and registers.
module fixed_point_complex_multiplier #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] ar,
  input  logic [WIDTH-1:0] ai,
  input  logic [WIDTH-1:0] wr,
  input  logic [WIDTH-1:0] wi,
  output logic [WIDTH-1:0] re,
  output logic [WIDTH-1:0] im,
  output logic             overflow,
  output logic             busy,
  output logic             done,
  output logic [2:0]       dbg_state
);

  localparam int PW = 2 * WIDTH;
  localparam int AW = 2 * WIDTH + 1;
  localparam logic signed [AW-1:0] SAT_MAX = AW'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
  localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_M0   = 3'd1,
    S_M1   = 3'd2,
    S_M2   = 3'd3,
    S_M3   = 3'd4,
    S_OUT  = 3'd5
  } state_t;

  state_t state_q, state_d;
  logic [WIDTH-1:0] ar_q, ar_d, ai_q, ai_d, wr_q, wr_d, wi_q, wi_d;
  logic signed [AW-1:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d;
  logic [WIDTH-1:0] re_q, re_d, im_q, im_d;
  logic overflow_q, overflow_d, busy_q, busy_d, done_q, done_d;

  logic [WIDTH-1:0] mul_a, mul_b;
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] prod_ext;
  logic [WIDTH:0] sat_re, sat_im;

  // Returns {saturated, value}; the arithmetic shift floors toward -inf.
  function automatic logic [WIDTH:0] saturate(input logic signed [AW-1:0] acc);
    logic signed [AW-1:0] s;
    s = acc >>> FRAC;
    if (s > SAT_MAX)      saturate = {1'b1, SAT_MAX[WIDTH-1:0]};
    else if (s < SAT_MIN) saturate = {1'b1, SAT_MIN[WIDTH-1:0]};
    else                  saturate = {1'b0, s[WIDTH-1:0]};
  endfunction

  assign prod     = $signed(mul_a) * $signed(mul_b);
  assign prod_ext = {prod[PW-1], prod};
  assign sat_re   = saturate(acc_re_q);
  assign sat_im   = saturate(acc_im_q);

  always_comb begin
    state_d    = state_q;
    ar_d       = ar_q;
    ai_d       = ai_q;
    wr_d       = wr_q;
    wi_d       = wi_q;
    acc_re_d   = acc_re_q;
    acc_im_d   = acc_im_q;
    re_d       = re_q;
    im_d       = im_q;
    overflow_d = 1'b0;
    done_d     = 1'b0;
    busy_d     = busy_q;
    mul_a      = ar_q;
    mul_b      = wr_q;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          ar_d    = ar;
          ai_d    = ai;
          wr_d    = wr;
          wi_d    = wi;
          busy_d  = 1'b1;
          state_d = S_M0;
        end
      end
      S_M0: begin
        mul_a    = ar_q;
        mul_b    = wr_q;
        acc_re_d = prod_ext;
        state_d  = S_M1;
      end
      S_M1: begin
        mul_a    = ai_q;
        mul_b    = wi_q;
        acc_re_d = acc_re_q - prod_ext;
        state_d  = S_M2;
      end
      S_M2: begin
        mul_a    = ar_q;
        mul_b    = wi_q;
        acc_im_d = prod_ext;
        state_d  = S_M3;
      end
      S_M3: begin
        mul_a    = ai_q;
        mul_b    = wr_q;
        acc_im_d = acc_im_q + prod_ext;
        state_d  = S_OUT;
      end
      S_OUT: begin
        re_d       = sat_re[WIDTH-1:0];
        im_d       = sat_im[WIDTH-1:0];
        overflow_d = sat_re[WIDTH] | sat_im[WIDTH];
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ar_q       <= '0;
      ai_q       <= '0;
      wr_q       <= '0;
      wi_q       <= '0;
      acc_re_q   <= '0;
      acc_im_q   <= '0;
      re_q       <= '0;
      im_q       <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ar_q       <= ar_d;
      ai_q       <= ai_d;
      wr_q       <= wr_d;
      wi_q       <= wi_d;
      acc_re_q   <= acc_re_d;
      acc_im_q   <= acc_im_d;
      re_q       <= re_d;
      im_q       <= im_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign re        = re_q;
  assign im        = im_q;
  assign overflow  = overflow_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fixed_point_complex_multiplier.sv
// Bench for the complex multiplier: directed vectors, expected results queued by the
// driver and popped by a done-triggered monitor.
module tb_fixed_point_complex_multiplier;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [15:0] ar, ai, wr, wi;
  logic [15:0] re, im;
  logic        overflow, busy, done;
  logic [2:0]  dbg_state;

  // Expected entry: {overflow, re, im}
  logic [32:0] exp_q[$];
  logic [32:0] mon_exp;
  int total;
  int bad;

  fixed_point_complex_multiplier #(.WIDTH(16), .FRAC(15)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .ar(ar), .ai(ai), .wr(wr), .wi(wi),
    .re(re), .im(im), .overflow(overflow), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every done pulse consumes one expected result.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no result pending at %0t", $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("result_re", {16'h0, re}, {16'h0, mon_exp[31:16]});
        check("result_im", {16'h0, im}, {16'h0, mon_exp[15:0]});
        check("result_overflow", {31'h0, overflow}, {31'h0, mon_exp[32]});
      end
    end
  end

  // Driver: called right after a negedge with the DUT idle (or in its done cycle).
  task automatic run_op(input logic [15:0] a_r, input logic [15:0] a_i,
                        input logic [15:0] w_r, input logic [15:0] w_i,
                        input logic [15:0] e_re, input logic [15:0] e_im, input logic e_ov);
    int lat;
    ar = a_r; ai = a_i; wr = w_r; wi = w_i;
    enable = 1'b1;
    exp_q.push_back({e_ov, e_re, e_im});
    @(negedge clk);
    enable = 1'b0;
    ar = 16'($urandom_range(0, 65535));
    ai = 16'($urandom_range(0, 65535));
    wr = 16'($urandom_range(0, 65535));
    wi = 16'($urandom_range(0, 65535));
    check("busy_after_accept", {31'h0, busy}, 32'h1);
    check("done_low_after_accept", {31'h0, done}, 32'h0);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c;
        break;
      end
    end
    check("done_latency", lat, 32'd5);
    check("busy_low_at_done", {31'h0, busy}, 32'h0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    enable = 1'b0;
    ar = 16'h0; ai = 16'h0; wr = 16'h0; wi = 16'h0;
    repeat (2) @(negedge clk);
    check("reset_re", {16'h0, re}, 32'h0);
    check("reset_im", {16'h0, im}, 32'h0);
    check("reset_flags", {29'h0, overflow, busy, done}, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_state", {29'h0, dbg_state}, 32'h0);

    // Back-to-back: each new op is issued during the previous done cycle.
    run_op(16'h4000, 16'h0000, 16'h4000, 16'h0000, 16'h2000, 16'h0000, 1'b0);
    run_op(16'h4000, 16'h4000, 16'h4000, 16'hC000, 16'h4000, 16'h0000, 1'b0);
    run_op(16'h8000, 16'h0000, 16'h8000, 16'h0000, 16'h7FFF, 16'h0000, 1'b1);
    run_op(16'h8000, 16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h0001, 1'b1);
    run_op(16'hFFFF, 16'h0000, 16'h4000, 16'h0000, 16'hFFFF, 16'h0000, 1'b0);
    run_op(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h7FFF, 16'hFFFF, 1'b1);
    run_op(16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h8000, 1'b1);
    run_op(16'h2000, 16'h1000, 16'h6000, 16'hE000, 16'h1C00, 16'h0400, 1'b0);
    @(negedge clk);
    check("done_single_pulse", {31'h0, done}, 32'h0);
    check("overflow_single_pulse", {31'h0, overflow}, 32'h0);
    check("re_held", {16'h0, re}, 32'h1C00);

    // Enable pulses while busy must be ignored.
    ar = 16'h4000; ai = 16'h4000; wr = 16'h4000; wi = 16'hC000;
    enable = 1'b1;
    exp_q.push_back({1'b0, 16'h4000, 16'h0000});
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    ar = 16'h8000; ai = 16'h0000; wr = 16'h8000; wi = 16'h0000;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    enable = 1'b0;
    repeat (12) @(negedge clk);
    check("ignored_enable_re_hold", {16'h0, re}, 32'h4000);
    check("ignored_enable_state", {29'h0, dbg_state}, 32'h0);

    // Reset in M2 aborts the op: no done, outputs cleared.
    ar = 16'h4000; ai = 16'h0000; wr = 16'h4000; wi = 16'h0000;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check("state_m2_before_reset", {29'h0, dbg_state}, 32'h3);
    reset = 1'b1;
    #1;
    check("abort_re", {16'h0, re}, 32'h0);
    check("abort_im", {16'h0, im}, 32'h0);
    check("abort_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_no_result", {16'h0, re}, 32'h0);
    check("abort_flags", {29'h0, overflow, busy, done}, 32'h0);
    check("queue_drained", exp_q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
